// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, ALU branch codes and sequencer state encoding.
package cpu_pkg;
    localparam int PC_W    = 32;
    localparam int BR_W    = 24;
    localparam int CODE_W  = 11;
    localparam int CODE_B  = 31;
    localparam int CODE_BL = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        LINK   = 3'd4,
        COMMIT = 3'd5,
        HALT   = 3'd6
    } state_e;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: branch target / sequential next-PC and link value, purely combinational.
module next_pc_calc #(
    parameter int PC_W    = cpu_pkg::PC_W,
    parameter int BR_W    = cpu_pkg::BR_W,
    parameter int CODE_W  = cpu_pkg::CODE_W,
    parameter int CODE_B  = cpu_pkg::CODE_B,
    parameter int CODE_BL = cpu_pkg::CODE_BL
) (
    input  logic [PC_W-1:0]   pc,
    input  logic [CODE_W-1:0] alu_ctl_code,
    input  logic [BR_W-1:0]   br_address,
    output logic [PC_W-1:0]   next_pc,
    output logic [PC_W-1:0]   link_value
);
    logic            is_br;
    logic [PC_W-1:0] br_sext;

    always_comb begin
        is_br      = (alu_ctl_code == CODE_W'(CODE_B)) || (alu_ctl_code == CODE_W'(CODE_BL));
        br_sext    = {{(PC_W-BR_W){br_address[BR_W-1]}}, br_address};
        next_pc    = pc + (is_br ? br_sext : PC_W'(1));
        link_value = pc + PC_W'(1);
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/decode/execute/link/commit controller owning the PC.
module pc_sequencer #(
    parameter int              PC_W     = cpu_pkg::PC_W,
    parameter int              BR_W     = cpu_pkg::BR_W,
    parameter int              CODE_W   = cpu_pkg::CODE_W,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CODE_B   = cpu_pkg::CODE_B,
    parameter int              CODE_BL  = cpu_pkg::CODE_BL
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              halt_req,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       instr,
    output logic [31:0]       instr_q,
    output logic              instr_valid,
    input  logic [CODE_W-1:0] alu_ctl_code,
    input  logic [BR_W-1:0]   br_address,
    input  logic              ex_done,
    output logic              lr_wr_en,
    output logic [PC_W-1:0]   lr_wr_data,
    input  logic              lr_wr_ack,
    output logic [PC_W-1:0]   pc,
    output logic              halted,
    output logic [2:0]        state_dbg
);
    import cpu_pkg::*;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, npc_q, npc_d, lr_q, lr_d, calc_npc, calc_link;
    logic [31:0]     instr_d;
    logic            halt_q, halt_d;

    next_pc_calc #(
        .PC_W(PC_W), .BR_W(BR_W), .CODE_W(CODE_W), .CODE_B(CODE_B), .CODE_BL(CODE_BL)
    ) u_calc (
        .pc          (pc_q),
        .alu_ctl_code(alu_ctl_code),
        .br_address  (br_address),
        .next_pc     (calc_npc),
        .link_value  (calc_link)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        lr_d    = lr_q;
        instr_d = instr_q;
        // halt request is remembered from FETCH until it is honoured at COMMIT
        halt_d  = halt_q | (halt_req && state_q != IDLE && state_q != HALT);
        case (state_q)
            IDLE:    state_d = run ? FETCH : IDLE;
            FETCH: begin
                if (imem_ack) begin
                    instr_d = instr;
                    state_d = DECODE;
                end
            end
            DECODE:  state_d = EXEC;
            EXEC: begin
                if (ex_done) begin
                    npc_d = calc_npc;
                    if (alu_ctl_code == CODE_W'(CODE_BL)) begin
                        lr_d    = calc_link;
                        state_d = LINK;
                    end else begin
                        state_d = COMMIT;
                    end
                end
            end
            LINK:    state_d = lr_wr_ack ? COMMIT : LINK;
            COMMIT: begin
                pc_d    = npc_q;
                state_d = halt_d ? HALT : (run ? FETCH : IDLE);
                halt_d  = 1'b0;
            end
            HALT:    state_d = run ? HALT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            npc_q   <= '0;
            lr_q    <= '0;
            instr_q <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            lr_q    <= lr_d;
            instr_q <= instr_d;
            halt_q  <= halt_d;
        end
    end

    assign imem_req    = state_q == FETCH;
    assign imem_addr   = pc_q;
    assign instr_valid = state_q == DECODE || state_q == EXEC;
    assign lr_wr_en    = state_q == LINK;
    assign lr_wr_data  = lr_q;
    assign pc          = pc_q;
    assign halted      = state_q == HALT;
    assign state_dbg   = state_q;
endmodule
